fm_disc_decim: RTL



---
 rtl/fm_disc_decim.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fm_disc_decim.sv
// Complex-baseband demodulator: cross-product FM discriminator or AM magnitude estimate,
// followed by accumulate-and-dump decimation, scaling, saturation, squelch and overflow flag.
module fm_disc_decim #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 16,
    parameter int ACC_W   = 48,
    parameter int DECIM   = 8,
    parameter int SHIFT   = 0,
    parameter int SQ_HOLD = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  i_in,
    input  logic signed [IN_W-1:0]  q_in,
    input  logic                    in_valid,
    input  logic                    mode,
    input  logic        [IN_W:0]    squelch_thr,
    input  logic                    clr_ovf,
    output logic signed [OUT_W-1:0] d_out,
    output logic                    out_valid,
    output logic                    squelch_open,
    output logic                    ovf
);
    localparam int P_W   = 2 * IN_W + 1;
    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int SQ_W  = $clog2(SQ_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic [SQ_W-1:0]  SQ_LIMIT = SQ_W'(SQ_HOLD);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic {SQ_CLOSED = 1'b0, SQ_OPEN = 1'b1} sq_state_t;

    function automatic logic [IN_W:0] abs_in(input logic signed [IN_W-1:0] x);
        logic [IN_W:0] xe;
        xe = {x[IN_W-1], x};
        return xe[IN_W] ? (~xe + {{IN_W{1'b0}}, 1'b1}) : xe;
    endfunction

    logic signed [IN_W-1:0]  ip_q, ip_d, qp_q, qp_d, i1_q, i1_d, q1_q, q1_d;
    logic signed [IN_W:0]    di1_q, di1_d, dq1_q, dq1_d;
    logic                    prime_q, prime_d, fmode_q, fmode_d;
    logic                    v1_q, v1_d, mode1_q, mode1_d, last1_q, last1_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    v2_q, v2_d, mode2_q, mode2_d, last2_q, last2_d;
    logic signed [P_W-1:0]   p1_q, p1_d, p2_q, p2_d;
    logic [IN_W:0]           mag2_q, mag2_d;
    sq_state_t               sq_state_q, sq_state_d;
    logic [SQ_W-1:0]         sq_cnt_q, sq_cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [OUT_W-1:0] d_out_q, d_out_d;
    logic                    out_valid_q, out_valid_d, ovf_q, ovf_d;

    logic [IN_W:0]           ai_s, aq_s, mag_s;
    logic [SQ_W-1:0]         sq_inc_s;
    logic signed [ACC_W-1:0] term_s, total_s, shifted_s;
    logic signed [OUT_W-1:0] sat_s;
    logic                    clamp_s, ovf_set_s;

    // Next-state logic for the three valid-gated pipeline stages, squelch and output.
    always_comb begin
        ip_d        = ip_q;
        qp_d        = qp_q;
        i1_d        = i1_q;
        q1_d        = q1_q;
        di1_d       = di1_q;
        dq1_d       = dq1_q;
        prime_d     = prime_q;
        fmode_d     = fmode_q;
        v1_d        = 1'b0;
        mode1_d     = mode1_q;
        last1_d     = last1_q;
        cnt_d       = cnt_q;
        v2_d        = 1'b0;
        mode2_d     = mode2_q;
        last2_d     = last2_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        mag2_d      = mag2_q;
        sq_state_d  = sq_state_q;
        sq_cnt_d    = sq_cnt_q;
        acc_d       = acc_q;
        d_out_d     = d_out_q;
        out_valid_d = 1'b0;
        ovf_set_s   = 1'b0;

        // S1: the first sample after reset only loads the previous-sample registers.
        if (in_valid) begin
            v1_d = 1'b1;
            i1_d = i_in;
            q1_d = q_in;
            if (prime_q) begin
                di1_d = {i_in[IN_W-1], i_in} - {ip_q[IN_W-1], ip_q};
                dq1_d = {q_in[IN_W-1], q_in} - {qp_q[IN_W-1], qp_q};
            end else begin
                di1_d = {(IN_W+1){1'b0}};
                dq1_d = {(IN_W+1){1'b0}};
            end
            ip_d    = i_in;
            qp_d    = q_in;
            prime_d = 1'b1;
            mode1_d = (cnt_q == {CNT_W{1'b0}}) ? mode : fmode_q;
            fmode_d = mode1_d;
            last1_d = (cnt_q == CNT_LAST);
            cnt_d   = last1_d ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
        end else begin
            v1_d = 1'b0;
        end

        ai_s = abs_in(i1_q);
        aq_s = abs_in(q1_q);
        if (ai_s >= aq_s) begin
            mag_s = ai_s + {1'b0, aq_s[IN_W:1]};
        end else begin
            mag_s = aq_s + {1'b0, ai_s[IN_W:1]};
        end
        sq_inc_s = sq_cnt_q + SQ_W'(1);

        if (v1_q) begin
            v2_d    = 1'b1;
            p1_d    = $signed({{(IN_W+1){i1_q[IN_W-1]}}, i1_q}) * $signed({{IN_W{dq1_q[IN_W]}}, dq1_q});
            p2_d    = $signed({{(IN_W+1){q1_q[IN_W-1]}}, q1_q}) * $signed({{IN_W{di1_q[IN_W]}}, di1_q});
            mag2_d  = mag_s;
            mode2_d = mode1_q;
            last2_d = last1_q;
            case (sq_state_q)
                SQ_CLOSED: begin
                    if (mag_s >= squelch_thr) begin
                        if (sq_inc_s == SQ_LIMIT) begin
                            sq_state_d = SQ_OPEN;
                            sq_cnt_d   = {SQ_W{1'b0}};
                        end else begin
                            sq_cnt_d = sq_inc_s;
                        end
                    end else begin
                        sq_cnt_d = {SQ_W{1'b0}};
                    end
                end
                SQ_OPEN: begin
                    if (mag_s < squelch_thr) begin
                        if (sq_inc_s == SQ_LIMIT) begin
                            sq_state_d = SQ_CLOSED;
                            sq_cnt_d   = {SQ_W{1'b0}};
                        end else begin
                            sq_cnt_d = sq_inc_s;
                        end
                    end else begin
                        sq_cnt_d = {SQ_W{1'b0}};
                    end
                end
                default: begin
                    sq_state_d = SQ_CLOSED;
                    sq_cnt_d   = {SQ_W{1'b0}};
                end
            endcase
        end else begin
            v2_d = 1'b0;
        end

        // S3: full-precision frame sum, scaled and clamped into the output range.
        if (mode2_q) begin
            term_s = $signed({{(ACC_W-IN_W-1){1'b0}}, mag2_q});
        end else begin
            term_s = $signed({{(ACC_W-P_W){p1_q[P_W-1]}}, p1_q})
                   - $signed({{(ACC_W-P_W){p2_q[P_W-1]}}, p2_q});
        end
        total_s   = acc_q + term_s;
        shifted_s = total_s >>> SHIFT;
        if (shifted_s > SAT_MAX) begin
            sat_s   = SAT_MAX[OUT_W-1:0];
            clamp_s = 1'b1;
        end else if (shifted_s < SAT_MIN) begin
            sat_s   = SAT_MIN[OUT_W-1:0];
            clamp_s = 1'b1;
        end else begin
            sat_s   = shifted_s[OUT_W-1:0];
            clamp_s = 1'b0;
        end

        if (v2_q) begin
            if (last2_q) begin
                acc_d       = {ACC_W{1'b0}};
                out_valid_d = 1'b1;
                if (sq_state_q == SQ_OPEN) begin
                    d_out_d   = sat_s;
                    ovf_set_s = clamp_s;
                end else begin
                    d_out_d = {OUT_W{1'b0}};
                end
            end else begin
                acc_d = total_s;
            end
        end else begin
            acc_d = acc_q;
        end

        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers; reset discards any partially accumulated frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ip_q        <= {IN_W{1'b0}};
            qp_q        <= {IN_W{1'b0}};
            i1_q        <= {IN_W{1'b0}};
            q1_q        <= {IN_W{1'b0}};
            di1_q       <= {(IN_W+1){1'b0}};
            dq1_q       <= {(IN_W+1){1'b0}};
            prime_q     <= 1'b0;
            fmode_q     <= 1'b0;
            v1_q        <= 1'b0;
            mode1_q     <= 1'b0;
            last1_q     <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            v2_q        <= 1'b0;
            mode2_q     <= 1'b0;
            last2_q     <= 1'b0;
            p1_q        <= {P_W{1'b0}};
            p2_q        <= {P_W{1'b0}};
            mag2_q      <= {(IN_W+1){1'b0}};
            sq_state_q  <= SQ_CLOSED;
            sq_cnt_q    <= {SQ_W{1'b0}};
            acc_q       <= {ACC_W{1'b0}};
            d_out_q     <= {OUT_W{1'b0}};
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            ip_q        <= ip_d;
            qp_q        <= qp_d;
            i1_q        <= i1_d;
            q1_q        <= q1_d;
            di1_q       <= di1_d;
            dq1_q       <= dq1_d;
            prime_q     <= prime_d;
            fmode_q     <= fmode_d;
            v1_q        <= v1_d;
            mode1_q     <= mode1_d;
            last1_q     <= last1_d;
            cnt_q       <= cnt_d;
            v2_q        <= v2_d;
            mode2_q     <= mode2_d;
            last2_q     <= last2_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            mag2_q      <= mag2_d;
            sq_state_q  <= sq_state_d;
            sq_cnt_q    <= sq_cnt_d;
            acc_q       <= acc_d;
            d_out_q     <= d_out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign d_out        = d_out_q;
    assign out_valid    = out_valid_q;
    assign squelch_open = (sq_state_q == SQ_OPEN);
    assign ovf          = ovf_q;

endmodule
